program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer-side companion to the processor's shared instruction/data memory. Receives a byte stream, e.g. from a UART receiver.
- Assembles big-endian 32-bit words and writes them into memory starting at BASE_ADDR.
- Holds the processor in reset until the image is fully loaded, then releases it.
- Sits beside the processor and drives the memory's write port while the processor is held.

Parameters:
- BASE_ADDR, 0, byte address of the first program word; must be a multiple of 4.
- MAX_WORDS, 1024, largest accepted word count; header counts above this are rejected.
- ADDR_WIDTH, 32, width of the memory address output.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- byteValid  in  1  byteData is valid this cycle.
- byteData  in  8  incoming stream byte.
- byteReady  out  1  loader accepts a byte this cycle; transfer occurs when byteValid && byteReady.
- memWrite  out  1  one-cycle memory write strobe.
- address  out  ADDR_WIDTH  memory byte address.
- writeData  out  32  word to write.
- cpuHold  out  1  keeps the processor in reset while high.
- loadDone  out  1  image loaded successfully; sticky.
- loadError  out  1  image rejected; sticky.
- wordsLoaded  out  16  number of words written so far.

Behaviour:
- Reset values (reset low, asynchronous): state=COUNT_HI, byteReady=0, memWrite=0, address=BASE_ADDR, writeData=0, cpuHold=1, loadDone=0, loadError=0, wordsLoaded=0, internal byte index=0.
- byteReady is high only in COUNT_HI, COUNT_LO, WORD and CHECK. Its first assertion is the first clock edge after reset deasserts.
- Stream format: count[15:8], count[7:0], then count words of 4 bytes each, MSB first. With the optional feature, one trailing checksum byte follows.
- COUNT_HI: on a transfer, latch the high byte, go to COUNT_LO.
- COUNT_LO: on a transfer, form count, then:
  - count=0 -> DONE (or CHECK if enabled);
  - count>MAX_WORDS -> ERROR;
  - otherwise -> WORD.
- WORD: each transfer shifts the byte into the word assembly register, MSB first. On the 4th byte go to WRITE; the byte index wraps 3->0.
- WRITE: exactly one cycle, with byteReady=0:
  - memWrite=1, address=BASE_ADDR+4*wordsLoaded, writeData=assembled word;
  - at the edge ending WRITE, wordsLoaded increments;
  - if the new wordsLoaded equals count -> DONE (or CHECK), else -> WORD.
- memWrite, address and writeData are registered outputs. Latency: the 4th byte's transfer edge to memWrite high is one cycle.
- DONE: cpuHold=0, loadDone=1, byteReady=0. Terminal until reset; further stream bytes are ignored.
- ERROR: cpuHold=1, loadError=1, byteReady=0. Terminal until reset.
- The address computation uses ADDR_WIDTH-bit wrap-around. No overflow check beyond the MAX_WORDS limit.
- byteValid while byteReady=0: the byte is not consumed, and the source must hold it.
- Reset asserted mid-load: all state returns immediately to reset values. Words already written to memory are not undone.
- memWrite is never high outside WRITE.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - an 8-bit XOR accumulator covers every byte from count[15:8] through the last word byte;
  - after the final word (or after COUNT_LO when count=0), enter CHECK and accept one byte;
  - byte equal to the accumulator -> DONE; otherwise -> ERROR;
  - the accumulator resets to 0.
- Not defined: no CHECK state and no accumulator; the final write goes directly to DONE.

Decomposition:
- Shared package (cpu_defs):
  - state encoding localparams for COUNT_HI, COUNT_LO, WORD, WRITE, CHECK, DONE, ERROR;
  - WORD_BYTES=4;
  - count field width of 16.
- One natural sub-module, byte_packer: shift register, 2-bit byte index, and word-complete pulse.
- The FSM, counters and memory outputs stay in the top module.

Test Plan:
- Count 0x0002, words 0x20080005 and 0xAC080000, BASE_ADDR=0, no stalls -> memWrite pulses at address 0x0 with 0x20080005 and at 0x4 with 0xAC080000; wordsLoaded=2; then cpuHold=0 and loadDone=1.
- Same image with byteValid toggling randomly -> identical writes; no byte is lost or duplicated; byteReady=0 during each WRITE cycle.
- Count 0x0401 with MAX_WORDS=1024 -> ERROR after the 2nd byte; loadError=1; cpuHold stays 1; no memWrite ever occurs.
- Count 0x0000 -> DONE; no writes; wordsLoaded=0 (with checksum: trailing byte 0x00 -> DONE, 0x01 -> ERROR).
- Reset pulsed low after 2 of 3 words -> outputs return to reset values asynchronously; a reloaded 1-word image writes at BASE_ADDR with wordsLoaded=1.
- LOADER_CHECKSUM_EN: count 0x0001, word 0x11223344, checksum 0x45 (0x00^0x01^0x11^0x22^0x33^0x44) -> DONE; checksum 0x46 -> ERROR with cpuHold=1.

Source files
------------

// File: rtl/cpu_defs.sv
// cpu_defs: shared definitions for the program loader.
// Holds the state encoding, the word geometry of the load stream and the
// width of the header word count.
package cpu_defs;

    // State encoding of the loader controller.
    localparam logic [2:0] ENC_COUNT_HI = 3'd0;
    localparam logic [2:0] ENC_COUNT_LO = 3'd1;
    localparam logic [2:0] ENC_WORD     = 3'd2;
    localparam logic [2:0] ENC_WRITE    = 3'd3;
    localparam logic [2:0] ENC_CHECK    = 3'd4;
    localparam logic [2:0] ENC_DONE     = 3'd5;
    localparam logic [2:0] ENC_ERROR    = 3'd6;

    typedef enum logic [2:0] {
        COUNT_HI = ENC_COUNT_HI,
        COUNT_LO = ENC_COUNT_LO,
        WORD     = ENC_WORD,
        WRITE    = ENC_WRITE,
        CHECK    = ENC_CHECK,
        DONE     = ENC_DONE,
        ERROR    = ENC_ERROR
    } loaderState_t;

    // Bytes per memory word, and the width of the byte index that walks them.
    localparam int WORD_BYTES       = 4;
    localparam int BYTE_INDEX_WIDTH = $clog2(WORD_BYTES);

    // Width of the big-endian word count at the head of the stream.
    localparam int COUNT_WIDTH = 16;

    // States in which the loader takes a byte from the stream.
    function automatic logic acceptsByte(input loaderState_t s);
        return s inside {COUNT_HI, COUNT_LO, WORD, CHECK};
    endfunction

endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles incoming stream bytes into a big-endian word.
// The first byte of a word lands in the most significant position. On the
// last byte of a word it raises wordComplete for that transfer cycle and
// presents the full word (including the byte being accepted) on packedWord.
module byte_packer
    import cpu_defs::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [7:0]              byteIn,
    output logic [8*WORD_BYTES-1:0] packedWord,
    output logic                    wordComplete
);

    localparam logic [BYTE_INDEX_WIDTH-1:0] LAST_INDEX =
        BYTE_INDEX_WIDTH'(WORD_BYTES - 1);

    // Only the earlier bytes of a word need storage; the final byte is
    // merged combinationally so the word is usable on its transfer edge.
    logic [8*(WORD_BYTES-1)-1:0] shiftReg;
    logic [BYTE_INDEX_WIDTH-1:0] byteIndex;

    // Shift each accepted byte in and advance the byte index (wraps to 0).
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shiftReg  <= '0;
            byteIndex <= '0;
        end else if (load) begin
            shiftReg  <= {shiftReg[8*(WORD_BYTES-2)-1:0], byteIn};
            byteIndex <= byteIndex + 1'b1;
        end
    end

    assign packedWord   = {shiftReg, byteIn};
    assign wordComplete = load && (byteIndex == LAST_INDEX);

endmodule

// File: rtl/program_loader.sv
// program_loader: writer-side companion of the shared instruction/data memory.
// Takes a byte stream (count[15:8], count[7:0], then count big-endian words),
// writes the words to memory starting at BASE_ADDR and holds the processor in
// reset until the image is complete.
// Optional build macro LOADER_CHECKSUM_EN: a trailing XOR checksum byte over
// the count and word bytes must match before the processor is released.
module program_loader
    import cpu_defs::*;
#(
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned MAX_WORDS  = 1024,
    parameter int          ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  byteValid,
    input  logic [7:0]            byteData,
    output logic                  byteReady,
    output logic                  memWrite,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [31:0]           writeData,
    output logic                  cpuHold,
    output logic                  loadDone,
    output logic                  loadError,
    output logic [15:0]           wordsLoaded
);

    localparam logic [ADDR_WIDTH-1:0]  BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [COUNT_WIDTH:0]   MAX_COUNT = (COUNT_WIDTH + 1)'(MAX_WORDS);

    // Where the stream goes once the last word (or an empty header) is taken.
`ifdef LOADER_CHECKSUM_EN
    localparam loaderState_t FINISH_STATE = CHECK;
`else
    localparam loaderState_t FINISH_STATE = DONE;
`endif

    loaderState_t            state;
    loaderState_t            nextState;
    logic                    transfer;
    logic [7:0]              countHi;
    logic [COUNT_WIDTH-1:0]  count;
    logic [COUNT_WIDTH-1:0]  countValue;
    logic [COUNT_WIDTH-1:0]  wordsNext;
    logic [ADDR_WIDTH-1:0]   wordOffset;
    logic [31:0]             packedWord;
    logic                    wordComplete;

    assign transfer   = byteValid && byteReady;
    assign countValue = {countHi, byteData};
    assign wordsNext  = wordsLoaded + 1'b1;
    assign wordOffset = ADDR_WIDTH'({wordsLoaded, 2'b00});

    byte_packer packer (
        .clock        (clock),
        .reset        (reset),
        .load         (transfer && (state == WORD)),
        .byteIn       (byteData),
        .packedWord   (packedWord),
        .wordComplete (wordComplete)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum;

    // Fold every header and word byte into the running XOR checksum.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            checksum <= 8'h00;
        end else if (transfer && (state != CHECK)) begin
            checksum <= checksum ^ byteData;
        end
    end
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= COUNT_HI;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: parse the header, collect words, finish or reject.
    // NOTE: nextState gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState = state;
        case (state)
            COUNT_HI: begin
                if (transfer) begin
                    nextState = COUNT_LO;
                end
            end
            COUNT_LO: begin
                if (transfer) begin
                    if (countValue == '0) begin
                        nextState = FINISH_STATE;
                    end else if ({1'b0, countValue} > MAX_COUNT) begin
                        nextState = ERROR;
                    end else begin
                        nextState = WORD;
                    end
                end
            end
            WORD: begin
                if (wordComplete) begin
                    nextState = WRITE;
                end
            end
            WRITE: begin
                if (wordsNext == count) begin
                    nextState = FINISH_STATE;
                end else begin
                    nextState = WORD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (transfer) begin
                    nextState = (byteData == checksum) ? DONE : ERROR;
                end
            end
`endif
            DONE:    nextState = DONE;
            ERROR:   nextState = ERROR;
            default: nextState = ERROR;
        endcase
    end

    // Header count capture and the count of words already written.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            countHi     <= 8'h00;
            count       <= '0;
            wordsLoaded <= '0;
        end else begin
            if (transfer && (state == COUNT_HI)) begin
                countHi <= byteData;
            end
            if (transfer && (state == COUNT_LO)) begin
                count <= countValue;
            end
            if (state == WRITE) begin
                wordsLoaded <= wordsNext;
            end
        end
    end

    // Registered outputs, decoded from the state being entered so each one
    // is valid in the same cycle as the state it belongs to.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byteReady <= 1'b0;
            memWrite  <= 1'b0;
            address   <= BASE;
            writeData <= '0;
            cpuHold   <= 1'b1;
            loadDone  <= 1'b0;
            loadError <= 1'b0;
        end else begin
            byteReady <= acceptsByte(nextState);
            memWrite  <= (nextState == WRITE);
            cpuHold   <= (nextState != DONE);
            loadDone  <= (nextState == DONE);
            loadError <= (nextState == ERROR);
            if (wordComplete) begin
                address   <= BASE + wordOffset;
                writeData <= packedWord;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized self-checking bench for program_loader.
// A reference model derives the expected memory writes and final status
// straight from the stream format; observed writes are collected by a monitor.
`timescale 1ns/1ps
module tb_program_loader;

    localparam int unsigned BASE_ADDR  = 0;
    localparam int unsigned MAX_WORDS  = 1024;
    localparam int          ADDR_WIDTH = 32;

    typedef logic [7:0] byteQ_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } writeRec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        byteValid = 1'b0;
    logic [7:0]  byteData = 8'h00;
    logic        byteReady;
    logic        memWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        cpuHold;
    logic        loadDone;
    logic        loadError;
    logic [15:0] wordsLoaded;

    program_loader #(
        .BASE_ADDR  (BASE_ADDR),
        .MAX_WORDS  (MAX_WORDS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .byteValid   (byteValid),
        .byteData    (byteData),
        .byteReady   (byteReady),
        .memWrite    (memWrite),
        .address     (address),
        .writeData   (writeData),
        .cpuHold     (cpuHold),
        .loadDone    (loadDone),
        .loadError   (loadError),
        .wordsLoaded (wordsLoaded)
    );

    always #5 clock = ~clock;

    int checkCount = 0;
    int errorCount = 0;
    writeRec_t obsWrites[$];
    writeRec_t expWrites[$];

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Record every memory write; the loader must not accept bytes meanwhile.
    always @(negedge clock) begin
        if (reset && memWrite) begin
            obsWrites.push_back('{address, writeData});
            check("readyDuringWrite", 32'(byteReady), 32'd0);
        end
    end

    function automatic logic [7:0] xorAll(input byteQ_t s);
        logic [7:0] acc = 8'h00;
        foreach (s[i]) acc ^= s[i];
        return acc;
    endfunction

    // Reference model: expected writes, final status and number of bytes the
    // loader consumes, computed directly from the stream layout.
    task automatic refModel(input byteQ_t s, output int consumed, output bit expDone,
                            output bit expError, output int expWords);
        int count;
        expWrites.delete();
        count    = int'({s[0], s[1]});
        consumed = 2;
        expDone  = 1'b0;
        expError = 1'b0;
        expWords = 0;
        if (count > int'(MAX_WORDS)) begin
            expError = 1'b1;
            return;
        end
        for (int w = 0; w < count; w++) begin
            expWrites.push_back('{32'(BASE_ADDR + 4 * w),
                                  {s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]}});
        end
        expWords = count;
        consumed = 2 + 4 * count;
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [7:0] sum = 8'h00;
            for (int i = 0; i < consumed; i++) sum ^= s[i];
            expDone  = (s[consumed] == sum);
            expError = !expDone;
            consumed++;
        end
`else
        expDone = 1'b1;
`endif
    endtask

    // Present one byte (optionally after random idle cycles) and hold it until
    // accepted. Called and returns at a falling edge.
    task automatic sendByte(input logic [7:0] b, input bit stall);
        int waited = 0;
        if (stall) begin
            while ($urandom_range(0, 2) == 0) begin
                byteValid = 1'b0;
                byteData  = 8'($urandom);
                @(negedge clock);
            end
        end
        byteValid = 1'b1;
        byteData  = b;
        while (!byteReady && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (!byteReady) check("readyTimeout", 32'(byteReady), 32'd1);
        @(negedge clock);
        byteValid = 1'b0;
    endtask

    task automatic applyReset();
        byteValid = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, ".byteReady"},   32'(byteReady),   32'd0);
        check({tag, ".memWrite"},    32'(memWrite),    32'd0);
        check({tag, ".address"},     address,          32'(BASE_ADDR));
        check({tag, ".writeData"},   writeData,        32'd0);
        check({tag, ".cpuHold"},     32'(cpuHold),     32'd1);
        check({tag, ".loadDone"},    32'(loadDone),    32'd0);
        check({tag, ".loadError"},   32'(loadError),   32'd0);
        check({tag, ".wordsLoaded"}, 32'(wordsLoaded), 32'd0);
    endtask

    task automatic runImage(input string tag, input byteQ_t s, input bit stall);
        int consumed;
        int expWords;
        int waitCycles;
        bit expDone;
        bit expError;
        refModel(s, consumed, expDone, expError, expWords);
        applyReset();
        obsWrites.delete();
        for (int i = 0; i < consumed; i++) begin
            sendByte(s[i], stall);
            if (i >= 2 && i < 2 + 4 * expWords && ((i - 2) % 4) == 3)
                check({tag, ".writeLatency"}, 32'(memWrite), 32'd1);
        end
        waitCycles = 0;
        while (!(loadDone || loadError) && waitCycles < 20) begin
            @(negedge clock);
            waitCycles++;
        end
        check({tag, ".loadDone"},    32'(loadDone),    32'(expDone));
        check({tag, ".loadError"},   32'(loadError),   32'(expError));
        check({tag, ".cpuHold"},     32'(cpuHold),     32'(!expDone));
        check({tag, ".wordsLoaded"}, 32'(wordsLoaded), 32'(expWords));
        check({tag, ".writeCount"},  32'(obsWrites.size()), 32'(expWrites.size()));
        for (int k = 0; k < obsWrites.size() && k < expWrites.size(); k++) begin
            check($sformatf("%s.addr[%0d]", tag, k), obsWrites[k].addr, expWrites[k].addr);
            check($sformatf("%s.data[%0d]", tag, k), obsWrites[k].data, expWrites[k].data);
        end
        // Once terminal, further stream bytes must be ignored.
        byteValid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            byteData = 8'($urandom);
            @(negedge clock);
            check({tag, ".readyTerminal"}, 32'(byteReady), 32'd0);
        end
        byteValid = 1'b0;
        check({tag, ".noLateWrites"}, 32'(obsWrites.size()), 32'(expWrites.size()));
        check({tag, ".statusHeld"}, 32'({loadDone, loadError}), 32'({expDone, expError}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        byteQ_t img;
        int count;

        // Reset values, then byteReady on the first edge after release.
        reset = 1'b0;
        #12;
        checkResetValues("reset");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("readyAfterReset", 32'(byteReady), 32'd1);

        // Two-word image, without and with random stalls.
        img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        img.push_back(xorAll(img));
`endif
        runImage("twoWords", img, 1'b0);
        runImage("twoWordsStall", img, 1'b1);

        // Count above MAX_WORDS is rejected after the header.
        img = '{8'h04, 8'h01};
        runImage("tooMany", img, 1'b0);

        // Empty image.
        img = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        img.push_back(8'h00);
        runImage("emptyGoodSum", img, 1'b0);
        img = '{8'h00, 8'h00, 8'h01};
        runImage("emptyBadSum", img, 1'b0);
        img = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        runImage("sumGood", img, 1'b0);
        img = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h46};
        runImage("sumBad", img, 1'b1);
`else
        runImage("empty", img, 1'b0);
`endif

        // Largest accepted image.
        img = '{8'(MAX_WORDS >> 8), 8'(MAX_WORDS)};
        for (int i = 0; i < 4 * int'(MAX_WORDS); i++) img.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
        img.push_back(xorAll(img));
`endif
        runImage("maxWords", img, 1'b0);

        // Reset in the middle of a 3-word image, then reload a 1-word image.
        img = '{8'h00, 8'h03};
        for (int i = 0; i < 12; i++) img.push_back(8'($urandom));
        applyReset();
        obsWrites.delete();
        for (int i = 0; i < 12; i++) sendByte(img[i], 1'b1);
        check("midLoad.writes", 32'(obsWrites.size()), 32'd2);
        @(negedge clock);
        #2 reset = 1'b0;
        #1 checkResetValues("midLoadReset");
        @(negedge clock);
        reset = 1'b1;
        img = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef LOADER_CHECKSUM_EN
        img.push_back(xorAll(img));
`endif
        runImage("reload", img, 1'b1);

        // Random images, including oversize counts and corrupt checksums.
        for (int t = 0; t < 10; t++) begin
            if ($urandom_range(0, 5) == 0) count = $urandom_range(int'(MAX_WORDS) + 1, 65535);
            else count = $urandom_range(0, 8);
            img = '{8'(count >> 8), 8'(count)};
            if (count <= int'(MAX_WORDS)) begin
                for (int i = 0; i < 4 * count; i++) img.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
                img.push_back(xorAll(img) ^ (($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00));
`endif
            end
            runImage($sformatf("random%0d", t), img, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
